pll_scaler_ctrl: RTL

//  Sequencer for the PLL output scaler. Accepts scale/bypass requests over a

---
 rtl/pll_pkg.sv | 25 ++
 rtl/pll_scaler_ctrl_if.sv | 14 +
 rtl/pll_cyc_timer.sv | 28 ++
 rtl/pll_scaler_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL sequencers: state encoding, default scale
// width and the helper that sizes the shared cycle counter.
package pll_pkg;

  localparam int SW_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_FINISH
  } pll_state_t;

  // Smallest width that can hold the largest of three cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_scaler_ctrl_if.sv
// Configuration request channel into the scaler sequencer (valid/ready).
interface pll_scaler_ctrl_if #(
  parameter int SW = pll_pkg::SW_DEFAULT
);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [SW-1:0] cfg_s;
  logic          cfg_bypass;

  modport master (output cfg_valid, cfg_s, cfg_bypass, input cfg_ready);
  modport slave  (input cfg_valid, cfg_s, cfg_bypass, output cfg_ready);

endinterface

// File: rtl/pll_cyc_timer.sv
// Loadable down-counter shared by the PLL sequencers; 'expired' marks the
// last cycle of a loaded interval (count of 1, or an idle count of 0).
module pll_cyc_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] cnt;

  // Stops at zero so an un-reloaded counter never wraps into a long interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt <= CW'(1));

endmodule

// File: rtl/pll_scaler_ctrl.sv
// Glitch-safe scaler update sequencer: force bypass, hold, load the new
// scale, optionally release bypass, settle, then confirm a scaler pulse.
module pll_scaler_ctrl
  import pll_pkg::*;
#(
  parameter int SW          = SW_DEFAULT,
  parameter int DEFAULT_S   = 3,
  parameter int BYPASS_HOLD = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pll_scaler_ctrl_if.slave  cfg,
  input  logic              scaled_in,
  output logic [SW-1:0]     s_out,
  output logic              bypass_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int HOLD_CYC = (BYPASS_HOLD < 1) ? 1 : BYPASS_HOLD;
  localparam int TO_CYC   = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int CW       = cnt_width(HOLD_CYC, SETTLE_CYC, TO_CYC);

  pll_state_t    state;
  pll_state_t    nxt;
  logic          ready_q;
  logic [SW-1:0] lat_s;
  logic          lat_bypass;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_expired;
  logic          transfer;
  logic          timeout;

  assign cfg.cfg_ready = ready_q;
  assign transfer      = (state == ST_IDLE) && cfg.cfg_valid && ready_q;
  assign timeout       = (state == ST_CHECK) && !scaled_in && tmr_expired;

  pll_cyc_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // The timer is reloaded on every state change with the length of the state
  // being entered, so one counter serves hold, settle and timeout.
  always_comb begin
    nxt      = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE:   if (transfer) nxt = ST_HOLD;
      ST_HOLD:   if (tmr_expired) nxt = ST_LOAD;
      ST_LOAD: begin
        if (lat_bypass)           nxt = ST_FINISH;
        else if (SETTLE_CYC == 0) nxt = ST_CHECK;
        else                      nxt = ST_SETTLE;
      end
      ST_SETTLE: if (tmr_expired) nxt = ST_CHECK;
      ST_CHECK:  if (scaled_in || tmr_expired) nxt = ST_FINISH;
      ST_FINISH: nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
    if (nxt != state) begin
      tmr_load = 1'b1;
      case (nxt)
        ST_HOLD:   tmr_val = CW'(HOLD_CYC);
        ST_SETTLE: tmr_val = CW'(SETTLE_CYC);
        ST_CHECK:  tmr_val = CW'(TO_CYC);
        default:   tmr_val = '0;
      endcase
    end
  end

  // On a timeout the scaler is parked in bypass but keeps the new factor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_out      <= SW'(DEFAULT_S);
      bypass_out <= 1'b1;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      lat_s      <= '0;
      lat_bypass <= 1'b0;
    end else begin
      ready_q <= (nxt == ST_IDLE);
      busy    <= (nxt != ST_IDLE);
      done    <= (nxt == ST_FINISH);
      if (transfer) begin
        lat_s      <= cfg.cfg_s;
        lat_bypass <= cfg.cfg_bypass;
        err        <= 1'b0;
        bypass_out <= 1'b1;
      end
      if (state == ST_LOAD) begin
        s_out <= lat_s;
        if (!lat_bypass) bypass_out <= 1'b0;
      end
      if (timeout) begin
        err        <= 1'b1;
        bypass_out <= 1'b1;
      end
    end
  end

endmodule
